// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH          = 32;
    localparam int DIV_BITS_PER_CYCLE = 4;
    localparam int DIV_ITERS          = DIV_WIDTH / DIV_BITS_PER_CYCLE;
    localparam int DIV_CNT_W          = $clog2(DIV_ITERS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/div_array_slice.sv
// Combinational slice of an unsigned restoring array divider: BITS_PER_CYCLE
// subtract-and-restore rows, each WIDTH+1 bits wide, MSB quotient bit first.
module div_array_slice #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [WIDTH-1:0]          rem_in,
    input  logic [BITS_PER_CYCLE-1:0] dvd_bits,
    input  logic [WIDTH-1:0]          divisor,
    output logic [BITS_PER_CYCLE-1:0] q_bits,
    output logic [WIDTH-1:0]          rem_out
);

    // Remainder entering each row; row r feeds row r+1.
    logic [WIDTH-1:0] rem_chain_s [0:BITS_PER_CYCLE];
    // Row operand: previous remainder shifted left with the next dividend bit.
    logic [WIDTH:0]   shifted_s   [0:BITS_PER_CYCLE-1];
    // Low WIDTH columns of shifted - divisor plus their carry out.
    logic [WIDTH:0]   low_sum_s   [0:BITS_PER_CYCLE-1];
    logic [BITS_PER_CYCLE-1:0] carry_s;

    assign rem_chain_s[0] = rem_in;

    for (genvar r = 0; r < BITS_PER_CYCLE; r++) begin : g_row
        assign shifted_s[r] = {rem_chain_s[r], dvd_bits[BITS_PER_CYCLE-1-r]};
        // a + ~b + 1 over the low WIDTH columns; the carry means a >= b there.
        assign low_sum_s[r] = {1'b0, shifted_s[r][WIDTH-1:0]}
                            + {1'b0, ~divisor}
                            + {{WIDTH{1'b0}}, 1'b1};
        // The divisor's top column is zero, so the cell carries out whenever
        // the shifted remainder's top bit is set or the low columns carry.
        assign carry_s[r] = shifted_s[r][WIDTH] | low_sum_s[r][WIDTH];
        // Carry selects the difference, otherwise the shifted value is restored.
        assign rem_chain_s[r+1] = carry_s[r] ? low_sum_s[r][WIDTH-1:0]
                                             : shifted_s[r][WIDTH-1:0];
        assign q_bits[BITS_PER_CYCLE-1-r] = carry_s[r];
    end

    assign rem_out = rem_chain_s[BITS_PER_CYCLE];

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed divider front end: latches operands on ctrl_DIV, runs the
// array slice once per cycle, then applies sign and exception fix-up.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH          = DIV_WIDTH,
    parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int QHI_W = WIDTH - BITS_PER_CYCLE;

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Unsigned magnitude; the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;      // shifting dividend magnitude
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [QHI_W-1:0] quo_r;      // quotient bits retired so far
    logic [WIDTH-1:0] divisor_r;  // divisor magnitude
    logic             sign_r;
    logic             zero_r;
    logic             ovf_r;

    logic [BITS_PER_CYCLE-1:0] q_bits_s;
    logic [WIDTH-1:0]          rem_next_s;
    logic [WIDTH-1:0]          quo_next_s;
    logic [WIDTH-1:0]          result_next_s;

    div_array_slice #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_slice (
        .rem_in   (rem_r),
        .dvd_bits (dvd_r[WIDTH-1 -: BITS_PER_CYCLE]),
        .divisor  (divisor_r),
        .q_bits   (q_bits_s),
        .rem_out  (rem_next_s)
    );

    // Quotient after this iteration and its sign/exception-corrected form.
    always_comb begin
        quo_next_s    = {quo_r, q_bits_s};
        result_next_s = ZERO_W;
        if (zero_r) begin
            result_next_s = ZERO_W;
        end else if (ovf_r) begin
            result_next_s = MIN_NEG;
        end else if (sign_r) begin
            result_next_s = negate(quo_next_s);
        end else begin
            result_next_s = quo_next_s;
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            dvd_r          <= ZERO_W;
            rem_r          <= ZERO_W;
            quo_r          <= {QHI_W{1'b0}};
            divisor_r      <= ZERO_W;
            sign_r         <= 1'b0;
            zero_r         <= 1'b0;
            ovf_r          <= 1'b0;
            data_result    <= ZERO_W;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_DIV) begin
            // Load (or restart): any in-flight op is dropped without RDY.
            state_r        <= ST_RUN;
            cnt_r          <= {CNT_W{1'b0}};
            dvd_r          <= magnitude(data_operandA);
            rem_r          <= ZERO_W;
            quo_r          <= {QHI_W{1'b0}};
            divisor_r      <= magnitude(data_operandB);
            sign_r         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            zero_r         <= (data_operandB == ZERO_W);
            ovf_r          <= (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
            data_resultRDY <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_resultRDY <= 1'b0;
                end
                ST_RUN: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[WIDTH-BITS_PER_CYCLE-1:0], {BITS_PER_CYCLE{1'b0}}};
                    quo_r <= quo_next_s[QHI_W-1:0];
                    if (cnt_r == CNT_LAST) begin
                        state_r        <= ST_IDLE;
                        cnt_r          <= {CNT_W{1'b0}};
                        data_result    <= result_next_s;
                        data_exception <= zero_r | ovf_r;
                        data_resultRDY <= 1'b1;
                    end else begin
                        cnt_r          <= cnt_r + CNT_ONE;
                        data_resultRDY <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    cnt_r          <= {CNT_W{1'b0}};
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: the driver queues hand-computed results
// with their expected RDY edge, the monitor pops and checks on every RDY.
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          rdy_edge;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    div_seq_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Edge counter: after edge k, cyc == k.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Called at a falling edge; the pulse is sampled on the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] er, input logic ee, input string nm);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (push) sb.push_back('{er, ee, cyc + 1 + 8, nm});
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Monitor: every RDY must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rdy: got RDY=1 required no RDY (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, data_result, e.res);
                    check({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
                    check({e.name, "_latency"}, cyc, e.rdy_edge);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        idle(3);
        reset = 1'b0;
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

        issue(32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "pos_pos");                 idle(10);
        issue(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, "neg_pos");         idle(10);
        issue(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 1'b0, "pos_neg");         idle(10);
        issue(-32'sd100, -32'sd7, 1'b1, 32'd14, 1'b0, "neg_neg");              idle(10);
        issue(32'd7, 32'd0, 1'b1, 32'd0, 1'b1, "div_zero");                    idle(10);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, "ovf"); idle(10);
        issue(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b0, "min_by_one");  idle(10);
        issue(32'h7FFF_FFFF, 32'd16, 1'b1, 32'h07FF_FFFF, 1'b0, "max_by_16");  idle(10);
        issue(-32'sd7, 32'd0, 1'b1, 32'd0, 1'b1, "neg_div_zero");              idle(10);

        // Restart at N+3: only the second op reports, at N+11.
        issue(32'd100, 32'd7, 1'b0, 32'd0, 1'b0, "aborted");
        idle(2);
        issue(32'd50, 32'd5, 1'b1, 32'd10, 1'b0, "restart");                   idle(14);

        // Restart exactly on the finish edge N+8 suppresses that RDY.
        issue(32'd20, 32'd4, 1'b0, 32'd0, 1'b0, "aborted_at_finish");
        idle(7);
        issue(-32'sd9, 32'd2, 1'b1, 32'hFFFF_FFFC, 1'b0, "restart_on_finish"); idle(10);

        // Clean back-to-back at N+9.
        issue(32'd1000, 32'd10, 1'b1, 32'd100, 1'b0, "b2b_first");
        idle(8);
        issue(-32'sd1000, 32'd10, 1'b1, 32'hFFFF_FF9C, 1'b0, "b2b_second");    idle(10);

        // Reset at N+4 kills the op and clears outputs.
        issue(32'd100, 32'd7, 1'b0, 32'd0, 1'b0, "reset_killed");
        idle(3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrun_reset_result", data_result, 32'd0);
        check("midrun_reset_exception", {31'd0, data_exception}, 32'd0);
        check("midrun_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        idle(12);

        issue(32'd9, 32'd3, 1'b1, 32'd3, 1'b0, "after_reset");

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        idle(3);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
